// File: rtl/draw_player.sv
// draw_player: moves a square player sprite on a programmable tick, collects
// the active point once per overlap episode, and overlays both sprites onto
// the incoming VGA stream with exactly one cycle of latency.
module draw_player #(
    parameter int          SCREEN_W     = 800,
    parameter int          SCREEN_H     = 600,
    parameter int          PLAYER_HALF  = 16,
    parameter int          POINT_HALF   = 8,
    parameter int          MOVE_DIV     = 500000,
    parameter int          STEP         = 1,
    parameter int          SCORE_W      = 4,
    parameter int          START_X      = 32,
    parameter int          START_Y      = 32,
    parameter logic [11:0] PLAYER_COLOR = 12'hF00,
    parameter logic [11:0] POINT_COLOR  = 12'h0F0
) (
    input  logic               clk,
    input  logic               rst,
    // timing + colour from the background stage
    input  logic [10:0]        vga_in_hcount,
    input  logic [10:0]        vga_in_vcount,
    input  logic               vga_in_hsync,
    input  logic               vga_in_vsync,
    input  logic               vga_in_hblnk,
    input  logic               vga_in_vblnk,
    input  logic [11:0]        vga_in_rgb,
    // same stream, one cycle later, with sprites overlaid
    output logic [10:0]        vga_out_hcount,
    output logic [10:0]        vga_out_vcount,
    output logic               vga_out_hsync,
    output logic               vga_out_vsync,
    output logic               vga_out_hblnk,
    output logic               vga_out_vblnk,
    output logic [11:0]        vga_out_rgb,
    // movement requests and wall flags
    input  logic               move_up,
    input  logic               move_down,
    input  logic               move_right,
    input  logic               move_left,
    input  logic               blk_up,
    input  logic               blk_down,
    input  logic               blk_right,
    input  logic               blk_left,
    // point source handshake
    input  logic [10:0]        point_x,
    input  logic [10:0]        point_y,
    input  logic               point_valid,
    output logic               point_take,
    // status
    output logic [SCORE_W-1:0] score,
    output logic               score_sat,
    output logic [10:0]        xpos,
    output logic [10:0]        ypos
);

    localparam int CNT_W = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(MOVE_DIV - 1);
    localparam logic [11:0]        X_MIN     = 12'(PLAYER_HALF);
    localparam logic [11:0]        X_MAX     = 12'(SCREEN_W - PLAYER_HALF - 1);
    localparam logic [11:0]        Y_MIN     = 12'(PLAYER_HALF);
    localparam logic [11:0]        Y_MAX     = 12'(SCREEN_H - PLAYER_HALF - 1);
    localparam logic [11:0]        STEP_V    = 12'(STEP);
    localparam logic [11:0]        REACH     = 12'(PLAYER_HALF + POINT_HALF);
    localparam logic [11:0]        P_HALF    = 12'(PLAYER_HALF);
    localparam logic [11:0]        Q_HALF    = 12'(POINT_HALF);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        S_WAIT,
        S_ARMED,
        S_TAKE,
        S_DRAIN
    } state_t;

    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic [11:0]        x_cur;
    logic [11:0]        y_cur;
    logic [11:0]        x_next;
    logic [11:0]        y_next;
    logic [11:0]        dx;
    logic [11:0]        dy;
    logic               overlap;
    state_t             state_q;
    state_t             state_d;
    logic [SCORE_W-1:0] score_next;
    logic [11:0]        h_cur;
    logic [11:0]        v_cur;
    logic               active;
    logic               player_hit;
    logic               point_hit;
    logic [11:0]        rgb_next;

    // Inclusive box span [c-half+1, c+half], rearranged so nothing subtracts.
    function automatic logic in_span(input logic [11:0] p, input logic [11:0] c,
                                     input logic [11:0] half);
        return ((p + half) >= (c + 12'd1)) && (p <= (c + half));
    endfunction

    assign x_cur = {1'b0, xpos};
    assign y_cur = {1'b0, ypos};
    assign tick  = (cnt == CNT_LAST);

    // Free-running movement divider: one tick every MOVE_DIV cycles.
    always_ff @(posedge clk) begin
        // NOTE: registers use <= so every flop samples pre-edge values; = here would create order-dependent races.
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    // Next position: only the highest-priority request counts, and its wall flag vetoes the move.
    always_comb begin
        // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
        x_next = x_cur;
        y_next = y_cur;
        if (tick) begin
            if (move_up) begin
                if (!blk_up)
                    y_next = (y_cur >= Y_MIN + STEP_V) ? y_cur - STEP_V : Y_MIN;
            end else if (move_down) begin
                if (!blk_down)
                    y_next = (y_cur + STEP_V <= Y_MAX) ? y_cur + STEP_V : Y_MAX;
            end else if (move_right) begin
                if (!blk_right)
                    x_next = (x_cur + STEP_V <= X_MAX) ? x_cur + STEP_V : X_MAX;
            end else if (move_left) begin
                if (!blk_left)
                    x_next = (x_cur >= X_MIN + STEP_V) ? x_cur - STEP_V : X_MIN;
            end
        end
    end

    // Player position register.
    always_ff @(posedge clk) begin
        if (rst) begin
            xpos <= 11'(START_X);
            ypos <= 11'(START_Y);
        end else begin
            xpos <= 11'(x_next);
            ypos <= 11'(y_next);
        end
    end

    // Overlap test on the registered (pre-move) position.
    always_comb begin
        dx      = (x_cur >= {1'b0, point_x}) ? x_cur - {1'b0, point_x} : {1'b0, point_x} - x_cur;
        dy      = (y_cur >= {1'b0, point_y}) ? y_cur - {1'b0, point_y} : {1'b0, point_y} - y_cur;
        overlap = (dx < REACH) && (dy < REACH);
    end

    // Collect FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_WAIT;
        else     state_q <= state_d;
    end

    // Collect FSM next state: one collection per point, judged only on ticks.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WAIT:  if (point_valid) state_d = S_ARMED;
            S_ARMED: begin
                if (!point_valid)          state_d = S_WAIT;
                else if (tick && overlap)  state_d = S_TAKE;
            end
            S_TAKE:  state_d = S_DRAIN;
            S_DRAIN: if (!point_valid) state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    assign point_take = (state_q == S_TAKE);

    // Saturating score increment, applied while in TAKE.
    always_comb begin
        score_next = score;
        if (point_take && (score != SCORE_MAX))
            score_next = score + 1'b1;
    end

    // Score and its saturation flag update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            score     <= '0;
            score_sat <= 1'b0;
        end else begin
            score     <= score_next;
            score_sat <= (score_next == SCORE_MAX);
        end
    end

    // Pixel colour: player over point over background; blanked pixels untouched.
    always_comb begin
        h_cur      = {1'b0, vga_in_hcount};
        v_cur      = {1'b0, vga_in_vcount};
        active     = !vga_in_hblnk && !vga_in_vblnk;
        player_hit = active && in_span(h_cur, x_cur, P_HALF) && in_span(v_cur, y_cur, P_HALF);
        point_hit  = active && in_span(h_cur, {1'b0, point_x}, Q_HALF)
                            && in_span(v_cur, {1'b0, point_y}, Q_HALF);
        rgb_next   = vga_in_rgb;
        if (player_hit)                          rgb_next = PLAYER_COLOR;
        else if (point_hit && state_q == S_ARMED) rgb_next = POINT_COLOR;
    end

    // Output stage: timing delayed one cycle alongside the overlaid colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_out_hcount <= '0;
            vga_out_vcount <= '0;
            vga_out_hsync  <= 1'b0;
            vga_out_vsync  <= 1'b0;
            vga_out_hblnk  <= 1'b0;
            vga_out_vblnk  <= 1'b0;
            vga_out_rgb    <= '0;
        end else begin
            vga_out_hcount <= vga_in_hcount;
            vga_out_vcount <= vga_in_vcount;
            vga_out_hsync  <= vga_in_hsync;
            vga_out_vsync  <= vga_in_vsync;
            vga_out_hblnk  <= vga_in_hblnk;
            vga_out_vblnk  <= vga_in_vblnk;
            vga_out_rgb    <= rgb_next;
        end
    end

endmodule

// File: tb/tb_draw_player.sv
// tb_draw_player: directed stimulus against draw_player with a cycle-level
// behavioural model; every output is compared against the model on each
// falling edge, plus literal spot checks for the key scenarios.
module tb_draw_player;

    localparam int MOVE_DIV = 4;
    localparam int STEP     = 3;
    localparam int SCORE_W  = 2;
    localparam int PH       = 16;
    localparam int QH       = 8;
    localparam int SW       = 800;
    localparam int SH       = 600;
    localparam int SX       = 32;
    localparam int SY       = 32;
    localparam int SMAX     = (1 << SCORE_W) - 1;

    logic clk, rst;
    logic [10:0] in_h, in_v, out_h, out_v;
    logic in_hs, in_vs, in_hb, in_vb, out_hs, out_vs, out_hb, out_vb;
    logic [11:0] in_rgb, out_rgb;
    logic mv_u, mv_d, mv_r, mv_l, bk_u, bk_d, bk_r, bk_l;
    logic [10:0] px, py;
    logic pvalid, ptake, ssat;
    logic [SCORE_W-1:0] score;
    logic [10:0] xpos, ypos;

    draw_player #(
        .MOVE_DIV(MOVE_DIV), .STEP(STEP), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .rst(rst),
        .vga_in_hcount(in_h), .vga_in_vcount(in_v), .vga_in_hsync(in_hs),
        .vga_in_vsync(in_vs), .vga_in_hblnk(in_hb), .vga_in_vblnk(in_vb),
        .vga_in_rgb(in_rgb),
        .vga_out_hcount(out_h), .vga_out_vcount(out_v), .vga_out_hsync(out_hs),
        .vga_out_vsync(out_vs), .vga_out_hblnk(out_hb), .vga_out_vblnk(out_vb),
        .vga_out_rgb(out_rgb),
        .move_up(mv_u), .move_down(mv_d), .move_right(mv_r), .move_left(mv_l),
        .blk_up(bk_u), .blk_down(bk_d), .blk_right(bk_r), .blk_left(bk_l),
        .point_x(px), .point_y(py), .point_valid(pvalid), .point_take(ptake),
        .score(score), .score_sat(ssat), .xpos(xpos), .ypos(ypos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Collection progress: 0 idle, 1 point shown & collectable, 2 collecting, 3 waiting for removal.
    int          m_x, m_y, m_score, m_phase, m_cycles;
    bit          m_sat, m_take, model_ok;
    logic [11:0] m_rgb;
    logic [25:0] m_timing;

    function automatic bit in_box(int h, int v, int cx, int cy, int half);
        return (h >= cx - half + 1) && (h <= cx + half) && (v >= cy - half + 1) && (v <= cy + half);
    endfunction

    function automatic int iabs(int a);
        return (a < 0) ? -a : a;
    endfunction

    task model_step();
        bit tick, ov, act;
        if (rst) begin
            m_x = SX; m_y = SY; m_score = 0; m_sat = 0; m_take = 0;
            m_phase = 0; m_cycles = 0; m_rgb = '0; m_timing = '0;
            model_ok = 1;
        end else if (model_ok) begin
            tick = (m_cycles % MOVE_DIV) == MOVE_DIV - 1;
            act  = !in_hb && !in_vb;
            if (act && in_box(in_h, in_v, m_x, m_y, PH))
                m_rgb = 12'hF00;
            else if (act && m_phase == 1 && in_box(in_h, in_v, px, py, QH))
                m_rgb = 12'h0F0;
            else
                m_rgb = in_rgb;
            m_timing = {in_h, in_v, in_hs, in_vs, in_hb, in_vb};
            ov = iabs(m_x - int'(px)) < PH + QH && iabs(m_y - int'(py)) < PH + QH;
            case (m_phase)
                0: if (pvalid) m_phase = 1;
                1: if (!pvalid) m_phase = 0; else if (tick && ov) m_phase = 2;
                2: begin
                    if (m_score < SMAX) m_score++;
                    m_phase = 3;
                end
                default: if (!pvalid) m_phase = 0;
            endcase
            m_sat  = (m_score == SMAX);
            m_take = (m_phase == 2);
            if (tick) begin
                if (mv_u)      begin if (!bk_u) m_y = (m_y - STEP < PH) ? PH : m_y - STEP; end
                else if (mv_d) begin if (!bk_d) m_y = (m_y + STEP > SH - PH - 1) ? SH - PH - 1 : m_y + STEP; end
                else if (mv_r) begin if (!bk_r) m_x = (m_x + STEP > SW - PH - 1) ? SW - PH - 1 : m_x + STEP; end
                else if (mv_l) begin if (!bk_l) m_x = (m_x - STEP < PH) ? PH : m_x - STEP; end
            end
            m_cycles++;
        end
    endtask

    always @(posedge clk) model_step();

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            check("xpos", xpos, m_x);
            check("ypos", ypos, m_y);
            check("score", score, m_score);
            check("score_sat", ssat, m_sat);
            check("point_take", ptake, m_take);
            check("vga_rgb", out_rgb, m_rgb);
            check("vga_timing", {out_h, out_v, out_hs, out_vs, out_hb, out_vb}, m_timing);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input int h, input int v, input bit hb, input bit vb, input logic [11:0] c);
        in_h = 11'(h); in_v = 11'(v); in_hb = hb; in_vb = vb; in_rgb = c;
        in_hs = hb; in_vs = vb;
    endtask

    task automatic wait_take(input string name, input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            step(1);
            seen = ptake;
        end
        check(name, seen, 1);
    endtask

    typedef struct {
        int h; int v; bit hb; bit vb; logic [11:0] rgb; logic [11:0] exp;
    } pix_vec_t;

    pix_vec_t draw_tab[14] = '{
        '{200, 200, 0, 0, 12'h123, 12'h0F0},
        '{200, 200, 1, 0, 12'h123, 12'h123},
        '{200, 200, 0, 1, 12'h456, 12'h456},
        '{ 41,  19, 0, 0, 12'h123, 12'hF00},
        '{ 26,  19, 0, 0, 12'h123, 12'hF00},
        '{ 25,  19, 0, 0, 12'h123, 12'h123},
        '{ 57,  19, 0, 0, 12'h123, 12'hF00},
        '{ 58,  19, 0, 0, 12'hABC, 12'hABC},
        '{ 41,  35, 0, 0, 12'h123, 12'hF00},
        '{ 41,  36, 0, 0, 12'h123, 12'h123},
        '{192, 200, 0, 0, 12'h321, 12'h321},
        '{193, 200, 0, 0, 12'h321, 12'h0F0},
        '{208, 200, 0, 0, 12'h321, 12'h0F0},
        '{209, 200, 0, 0, 12'h321, 12'h321}
    };

    int exp_score[3] = '{2, 3, 3};
    int exp_sat[3]   = '{0, 1, 1};

    initial begin
        model_ok = 0;
        rst = 1;
        {mv_u, mv_d, mv_r, mv_l, bk_u, bk_d, bk_r, bk_l} = '0;
        px = '0; py = '0; pvalid = 0;
        pix(0, 0, 0, 0, 12'h000);
        step(2);
        check("reset_xpos", xpos, 32);
        check("reset_ypos", ypos, 32);
        check("reset_score", score, 0);
        check("reset_take", ptake, 0);
        check("reset_rgb", out_rgb, 0);

        // 1: three ticks of move_right
        rst = 0; mv_r = 1;
        step(12);
        check("t1_xpos", xpos, 41);
        check("t1_ypos", ypos, 32);

        // 2: upward clamp, then a blocked top-priority request freezes all movement
        mv_r = 0; mv_u = 1;
        step(20);
        check("t2_ypos_17", ypos, 17);
        step(12);
        check("t2_ypos_clamp", ypos, 16);
        mv_l = 1; bk_u = 1;
        step(8);
        check("t2_blk_x", xpos, 41);
        check("t2_blk_y", ypos, 16);
        mv_u = 0; mv_l = 0; bk_u = 0; mv_d = 1; mv_r = 1;
        step(4);
        check("t2_prio_x", xpos, 41);
        check("t2_prio_y", ypos, 19);
        mv_d = 0; mv_r = 0;

        // 3: single collection
        px = 11'd60; py = 11'd19; pvalid = 1;
        wait_take("t3_take_seen", 12);
        step(1);
        check("t3_take_width", ptake, 0);
        check("t3_score", score, 1);
        step(6);
        check("t3_drain_score", score, 1);
        pvalid = 0;
        step(2);

        // 5: draw overlay in ARMED, then with the point gone
        px = 11'd200; py = 11'd200; pvalid = 1;
        step(1);
        foreach (draw_tab[i]) begin
            pix(draw_tab[i].h, draw_tab[i].v, draw_tab[i].hb, draw_tab[i].vb, draw_tab[i].rgb);
            step(1);
            check($sformatf("t5_rgb_%0d", i), out_rgb, draw_tab[i].exp);
        end
        check("t5_hcount", out_h, 209);
        pvalid = 0;
        step(1);
        pix(200, 200, 0, 0, 12'h777);
        step(1);
        check("t5_wait_rgb", out_rgb, 12'h777);

        // 4: saturating score with repeated collections
        for (int i = 0; i < 3; i++) begin
            px = 11'd60; py = 11'd19; pvalid = 1; mv_r = (i == 2);
            wait_take($sformatf("t4_take_seen_%0d", i), 12);
            step(1);
            check($sformatf("t4_score_%0d", i), score, exp_score[i]);
            check($sformatf("t4_sat_%0d", i), ssat, exp_sat[i]);
            if (i == 0) begin
                pix(65, 19, 0, 0, 12'h5A5);
                step(1);
                check("t5_drain_rgb", out_rgb, 12'h5A5);
            end
            step(2);
            pvalid = 0; mv_r = 0;
            step(2);
        end

        // 6: reset asserted while collecting
        px = 11'd60; py = 11'd19; pvalid = 1;
        wait_take("t6_take_seen", 12);
        rst = 1; pvalid = 0;
        step(1);
        check("t6_take", ptake, 0);
        check("t6_score", score, 0);
        check("t6_sat", ssat, 0);
        check("t6_xpos", xpos, 32);
        check("t6_ypos", ypos, 32);
        rst = 0;

        // screen-edge clamps
        mv_r = 1;
        step(1100);
        check("clamp_right", xpos, SW - PH - 1);
        mv_r = 0; mv_d = 1;
        step(800);
        check("clamp_down", ypos, SH - PH - 1);
        mv_d = 0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
